dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage and the
//  256-bit-line data memory. Returns hits combinationally with no stall. On a miss it stalls
//  the CPU, writes back a dirty victim, refills the line from memory, then completes the access.
// PARAMETERS
//  NUM_LINES  32   cache lines (power of 2); index width IDX_W = log2(NUM_LINES) = 5
//  LINE_W     256  line width in bits (8 x 32-bit words); offset width OFF_W = 5
//  TAG_W      22   tag width = 32 - IDX_W - OFF_W
// PORTS
//  clk_i         in   1    clock; every register updates on the rising edge
//  rst_i         in   1    synchronous, active-high reset
//  cpu_req_i     in   1    load/store request valid
//  cpu_we_i      in   1    1 = store, 0 = load
//  cpu_addr_i    in   32   byte address; [1:0] ignored; held stable while cpu_stall_o=1
//  cpu_data_i    in   32   store data
//  cpu_data_o    out  32   load data; valid when cpu_req_i=1, cpu_we_i=0 and cpu_stall_o=0
//  cpu_stall_o   out  1    1 = access not complete; combinational
//  mem_enable_o  out  1    one-cycle pulse that starts a memory transaction
//  mem_write_o   out  1    1 = writeback, 0 = refill; held until mem_ack_i
//  mem_addr_o    out  32   line address {tag,idx,5'b0}; held until mem_ack_i
//  mem_data_o    out  256  victim line; held until mem_ack_i
//  mem_data_i    in   256  refill line; valid the cycle AFTER mem_ack_i
//  mem_ack_i     in   1    one-cycle transaction-complete pulse (fixed latency of 10 cycles)
// BEHAVIOUR
//  - Reset: all valid/dirty bits cleared, state IDLE; mem_enable_o=0, mem_write_o=0,
//    mem_addr_o=0, mem_data_o=0. cpu_stall_o follows the IDLE hit/miss logic.
//  - Address split: tag=[31:10], idx=[9:5], word=[4:2].
//    hit = cpu_req_i & valid[idx] & (tag_arr[idx]==tag).
//  - cpu_stall_o = cpu_req_i & ~(state==IDLE & hit). It is 0 when cpu_req_i=0.
//  - Load hit: cpu_data_o = data_arr[idx][word*32 +: 32] in the same cycle.
//  - Store hit: at the clock edge the word is written and dirty[idx] is set.
//  - FSM states: IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RF_FILL.
//    IDLE    miss & valid & dirty -> WB_REQ; miss otherwise -> RF_REQ.
//    WB_REQ  mem_enable_o=1, mem_write_o=1, addr={victim tag,idx,0}, data=victim -> WB_WAIT.
//    WB_WAIT enable=0, outputs held; on mem_ack_i -> RF_REQ.
//    RF_REQ  mem_enable_o=1, mem_write_o=0, addr={cpu tag,idx,0} -> RF_WAIT.
//    RF_WAIT on mem_ack_i -> RF_FILL.
//    RF_FILL capture mem_data_i into line; set tag, valid=1, dirty=0 -> IDLE.
//  - After RF_FILL the access hits in IDLE: a load returns data, a store merges its word and sets dirty.
//  - Miss latency: clean line = 13 cycles stalled; dirty line = 25 cycles stalled.
//  - mem_enable_o is never high in the cycle after mem_ack_i, so memory never restarts spuriously.
//  - A miss on an invalid line never triggers a writeback (dirty implies valid).
//  - cpu_req_i dropping during a miss: the in-flight transaction still completes, then the FSM
//    returns to IDLE.
//  - rst_i mid-transaction: the FSM returns to IDLE and line contents are discarded.
//    The memory must be reset in the same cycle.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
//    Each counts IDLE-state accesses: hit_cnt_o +1 per completed hit cycle, miss_cnt_o +1 on
//    each IDLE->miss transition. Both reset to 0 and wrap modulo 2^32.
//  Undefined: these ports and counters do not exist.
// STRUCTURE
//  - dcache_pkg: FSM state encoding, IDX_W/OFF_W/TAG_W constants, and address-field slice helpers.
//  - Sub-module dcache_sram: tag, valid, dirty and data arrays. It has one synchronous write
//    port (line write or masked word write) and a combinational read port indexed by idx.
//  - The controller owns the FSM and the memory-side output registers.
// TESTING
//  1. Reset, then load 0x0000_0040: stall for 13 cycles, one refill (mem_write_o=0,
//     mem_addr_o=0x40), then returns memory word 0.
//  2. Store 0xDEADBEEF to 0x44 after test 1: no stall, dirty[2]=1; load 0x44 returns 0xDEADBEEF.
//  3. Load 0x0000_0444 (same idx 2, new tag): writeback at 0x40 containing 0xDEADBEEF, then a
//     refill at 0x440; stall lasts 25 cycles.
//  4. Load the other line at idx 2 while it is clean: no writeback, 13-cycle stall.
//  5. Assert rst_i during RF_WAIT: IDLE next cycle and all lines invalid; the next load at the
//     same address misses.
//  6. With DCACHE_STATS_EN and the sequence above: hit_cnt_o and miss_cnt_o match a scoreboard.
//     Check that mem_enable_o is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped L1 data cache: geometry constants,
// controller state encoding and address-field helpers.
// ---------------------------------------------------------------------------
package dcache_pkg;

   localparam int NUM_LINES = 32;
   localparam int LINE_W    = 256;
   localparam int IDX_W     = 5;
   localparam int OFF_W     = 5;
   localparam int TAG_W     = 32 - IDX_W - OFF_W;
   localparam int WSEL_W    = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WB_REQ  = 3'd1,
      ST_WB_WAIT = 3'd2,
      ST_RF_REQ  = 3'd3,
      ST_RF_WAIT = 3'd4,
      ST_RF_FILL = 3'd5
   } state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
      return addr[31:IDX_W+OFF_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
      return addr[OFF_W +: IDX_W];
   endfunction

   function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] addr);
      return addr[2 +: WSEL_W];
   endfunction

   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

   function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                             input logic [WSEL_W-1:0] w);
      return line[{w, 5'b00000} +: 32];
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// ---------------------------------------------------------------------------
// dcache_sram
// Tag / valid / dirty / data storage for the data cache. One combinational
// read port and one synchronous write port, both addressed by idx_i.
//   clk_i, rst_i        : clock, synchronous active-high reset (clears valid/dirty)
//   idx_i               : line index for read and write
//   valid_o, dirty_o,
//   tag_o, line_o       : contents of line idx_i
//   fill_i, fill_tag_i,
//   fill_line_i         : whole-line write; line becomes valid and clean
//   store_i, store_word_i,
//   store_data_i        : single-word write; line becomes dirty
// ---------------------------------------------------------------------------
module dcache_sram
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic              valid_o,
   output logic              dirty_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic [LINE_W-1:0] line_o,
   input  logic              fill_i,
   input  logic [TAG_W-1:0]  fill_tag_i,
   input  logic [LINE_W-1:0] fill_line_i,
   input  logic              store_i,
   input  logic [WSEL_W-1:0] store_word_i,
   input  logic [31:0]       store_data_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign line_o  = data_q[idx_i];

   // Line state bits; a fill always leaves the line clean, so dirty implies valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (store_i) begin
         dirty_q[idx_i] <= 1'b1;
      end else begin
         valid_q <= valid_q;
         dirty_q <= dirty_q;
      end
   end

   // Tag and data payload; not reset, invalid lines are never observed.
   always_ff @(posedge clk_i) begin
      if (fill_i) begin
         tag_q[idx_i]  <= fill_tag_i;
         data_q[idx_i] <= fill_line_i;
      end else if (store_i) begin
         data_q[idx_i][{store_word_i, 5'b00000} +: 32] <= store_data_i;
      end else begin
         tag_q[idx_i]  <= tag_q[idx_i];
         data_q[idx_i] <= data_q[idx_i];
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
// Direct-mapped, write-back, write-allocate L1 data cache. Hits complete in
// the request cycle; misses stall the CPU while a dirty victim is written
// back and the line is refilled from the 256-bit data memory.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   cpu_*          : CPU request (req/we/addr/data in), load data and stall out
//   mem_enable_o   : one-cycle pulse starting a memory transaction
//   mem_write_o    : 1 = writeback, 0 = refill
//   mem_addr_o     : line address of the transaction
//   mem_data_o     : victim line for writebacks
//   mem_data_i     : refill line, valid the cycle after mem_ack_i
//   mem_ack_i      : transaction-complete pulse
// Optional build macro DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o counters.
// ---------------------------------------------------------------------------
module dcache_controller
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   state_e             state_q;
   logic               mem_enable_q;
   logic               mem_write_q;
   logic [31:0]        mem_addr_q;
   logic [LINE_W-1:0]  mem_data_q;
   // Missing line is latched so a dropped request cannot redirect the refill.
   logic [TAG_W-1:0]   miss_tag_q;
   logic [IDX_W-1:0]   miss_idx_q;

   logic [TAG_W-1:0]   cpu_tag_s;
   logic [IDX_W-1:0]   cpu_idx_s;
   logic [WSEL_W-1:0]  cpu_word_s;
   logic [IDX_W-1:0]   arr_idx_s;
   logic               line_valid_s;
   logic               line_dirty_s;
   logic [TAG_W-1:0]   line_tag_s;
   logic [LINE_W-1:0]  line_data_s;
   logic               hit_s;
   logic               idle_hit_s;
   logic               miss_start_s;

   assign cpu_tag_s    = addr_tag(cpu_addr_i);
   assign cpu_idx_s    = addr_idx(cpu_addr_i);
   assign cpu_word_s   = addr_word(cpu_addr_i);
   assign arr_idx_s    = (state_q == ST_IDLE) ? cpu_idx_s : miss_idx_q;

   assign hit_s        = cpu_req_i & line_valid_s & (line_tag_s == cpu_tag_s);
   assign idle_hit_s   = (state_q == ST_IDLE) & hit_s;
   assign miss_start_s = (state_q == ST_IDLE) & cpu_req_i & ~hit_s;

   assign cpu_stall_o  = cpu_req_i & ~idle_hit_s;
   assign cpu_data_o   = line_word(line_data_s, cpu_word_s);

   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

   dcache_sram u_sram (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .idx_i        (arr_idx_s),
      .valid_o      (line_valid_s),
      .dirty_o      (line_dirty_s),
      .tag_o        (line_tag_s),
      .line_o       (line_data_s),
      .fill_i       (state_q == ST_RF_FILL),
      .fill_tag_i   (miss_tag_q),
      .fill_line_i  (mem_data_i),
      .store_i      (idle_hit_s & cpu_we_i),
      .store_word_i (cpu_word_s),
      .store_data_i (cpu_data_i)
   );

   // Miss FSM with registered memory-side outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'h0000_0000;
         mem_data_q   <= '0;
         miss_tag_q   <= '0;
         miss_idx_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (miss_start_s) begin
                  miss_tag_q   <= cpu_tag_s;
                  miss_idx_q   <= cpu_idx_s;
                  mem_enable_q <= 1'b1;
                  if (line_valid_s && line_dirty_s) begin
                     state_q     <= ST_WB_REQ;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= line_addr(line_tag_s, cpu_idx_s);
                     mem_data_q  <= line_data_s;
                  end else begin
                     state_q     <= ST_RF_REQ;
                     mem_write_q <= 1'b0;
                     mem_addr_q  <= line_addr(cpu_tag_s, cpu_idx_s);
                  end
               end else begin
                  state_q      <= ST_IDLE;
                  mem_enable_q <= 1'b0;
               end
            end
            ST_WB_REQ: begin
               mem_enable_q <= 1'b0;
               state_q      <= ST_WB_WAIT;
            end
            ST_WB_WAIT: begin
               if (mem_ack_i) begin
                  state_q <= ST_RF_REQ;
               end else begin
                  state_q <= ST_WB_WAIT;
               end
            end
            ST_RF_REQ: begin
               // Entered straight from IDLE the pulse is already out. Entered
               // right after a writeback ack, the pulse is launched one cycle
               // late so enable never follows an ack directly.
               if (mem_enable_q) begin
                  mem_enable_q <= 1'b0;
                  state_q      <= ST_RF_WAIT;
               end else begin
                  mem_enable_q <= 1'b1;
                  mem_write_q  <= 1'b0;
                  mem_addr_q   <= line_addr(miss_tag_q, miss_idx_q);
               end
            end
            ST_RF_WAIT: begin
               if (mem_ack_i) begin
                  state_q <= ST_RF_FILL;
               end else begin
                  state_q <= ST_RF_WAIT;
               end
            end
            ST_RF_FILL: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q      <= ST_IDLE;
               mem_enable_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] hit_cnt_d;
   logic [31:0] miss_cnt_q;
   logic [31:0] miss_cnt_d;

   // Next values of the access statistics; both wrap naturally.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (idle_hit_s) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
         hit_cnt_d = hit_cnt_q;
      end
      if (miss_start_s) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end else begin
         miss_cnt_d = miss_cnt_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// ---------------------------------------------------------------------------
// tb_dcache_controller
// Self-checking bench for dcache_controller: directed scenarios followed by
// random load/store traffic, checked against a transaction-level cache model
// and a fixed-latency memory device model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dcache_controller;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_cnt_o;
   logic [31:0]  miss_cnt_o;
`endif

   always #5 clk = ~clk;

   dcache_controller dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_data_o   (cpu_data_o),
      .cpu_stall_o  (cpu_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt_o    (hit_cnt_o),
      .miss_cnt_o   (miss_cnt_o)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Power-on memory contents: each word holds its own byte address, scrambled.
   function automatic logic [255:0] init_line(input logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w * 4)) ^ 32'hA5A5_0000;
      return l;
   endfunction

   // ---------------- reference model ----------------
   typedef struct packed {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] line;
   } tx_t;

   tx_t          exp_q[$];
   logic [255:0] bmem [logic [31:0]];
   bit           m_valid [32];
   bit           m_dirty [32];
   logic [21:0]  m_tag   [32];
   logic [255:0] m_line  [32];
   int           m_hits;
   int           m_misses;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_hits   = 0;
      m_misses = 0;
      exp_q.delete();
   endfunction

   function automatic logic [255:0] backing(input logic [31:0] la);
      if (bmem.exists(la)) return bmem[la];
      return init_line(la);
   endfunction

   // One complete CPU access: predicts stall length, memory traffic and load data.
   function automatic void model_access(input bit we, input logic [31:0] addr,
                                        input logic [31:0] wd, output int stall,
                                        output logic [31:0] rd);
      int          idx = int'(addr[9:5]);
      int          w   = int'(addr[4:2]);
      logic [31:0] la  = {addr[31:5], 5'b00000};
      logic [31:0] victim;
      tx_t         t;
      stall = 0;
      if (!(m_valid[idx] && m_tag[idx] == addr[31:10])) begin
         m_misses++;
         if (m_valid[idx] && m_dirty[idx]) begin
            victim = {m_tag[idx], addr[9:5], 5'b00000};
            t.wr = 1'b1; t.addr = victim; t.line = m_line[idx];
            exp_q.push_back(t);
            bmem[victim] = m_line[idx];
            stall = 25;
         end else begin
            stall = 13;
         end
         t.wr = 1'b0; t.addr = la; t.line = '0;
         exp_q.push_back(t);
         m_line[idx]  = backing(la);
         m_tag[idx]   = addr[31:10];
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
      end
      m_hits++;
      if (we) begin
         m_line[idx][w*32 +: 32] = wd;
         m_dirty[idx] = 1'b1;
      end
      rd = m_line[idx][w*32 +: 32];
   endfunction

   // ---------------- memory device model ----------------
   logic [255:0] dev_mem [logic [31:0]];
   int unsigned  cyc;

   function automatic logic [255:0] dev_read(input logic [31:0] la);
      if (dev_mem.exists(la)) return dev_mem[la];
      return init_line(la);
   endfunction

   initial begin : mem_device
      logic [31:0]  pend_addr;
      logic         pend_wr;
      logic [255:0] pend_line;
      logic [255:0] rf_line;
      bit           busy, rf_valid, prev_en, prev_ack;
      int unsigned  ack_cyc, rf_cyc;
      tx_t          t;
      busy = 1'b0; rf_valid = 1'b0; prev_en = 1'b0; prev_ack = 1'b0;
      ack_cyc = 0; rf_cyc = 0; cyc = 0;
      pend_addr = '0; pend_wr = 1'b0; pend_line = '0; rf_line = '0;
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst_i) begin
            busy     = 1'b0;
            rf_valid = 1'b0;
         end
         #1;
         mem_ack_i = 1'b0;
         for (int w = 0; w < 8; w++) mem_data_i[w*32 +: 32] = $urandom;
         if (rf_valid && cyc == rf_cyc) begin
            mem_data_i = rf_line;
            rf_valid   = 1'b0;
         end
         if (busy && cyc == ack_cyc) begin
            mem_ack_i = 1'b1;
            busy      = 1'b0;
            if (pend_wr) begin
               dev_mem[pend_addr] = pend_line;
            end else begin
               rf_line  = dev_read(pend_addr);
               rf_cyc   = cyc + 1;
               rf_valid = 1'b1;
            end
         end
         @(negedge clk);
         if (mem_enable_o) begin
            chk("en_back_to_back", 256'(prev_en), 256'(0));
            chk("en_after_ack", 256'(prev_ack), 256'(0));
            chk("en_while_busy", 256'(busy), 256'(0));
            if (exp_q.size() == 0) begin
               chk("unexpected_mem_tx", 256'({mem_write_o, mem_addr_o}), 256'(0));
            end else begin
               t = exp_q.pop_front();
               chk("mem_tx_write", 256'(mem_write_o), 256'(t.wr));
               chk("mem_tx_addr", 256'(mem_addr_o), 256'(t.addr));
               if (t.wr) chk("wb_line", mem_data_o, t.line);
            end
            busy      = 1'b1;
            pend_wr   = mem_write_o;
            pend_addr = mem_addr_o;
            pend_line = mem_data_o;
            ack_cyc   = cyc + 10;
         end else if (busy) begin
            chk("mem_hold", 256'({mem_write_o, mem_addr_o}), 256'({pend_wr, pend_addr}));
            if (pend_wr) chk("mem_hold_data", mem_data_o, pend_line);
         end
         prev_en  = mem_enable_o;
         prev_ack = mem_ack_i;
      end
   end

   // ---------------- CPU side ----------------
   // Starts at 1 ns after a rising edge; returns at the same point of a later cycle.
   task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
      int          exp_stall;
      logic [31:0] exp_rd;
      int          stalls;
      model_access(we, addr, wd, exp_stall, exp_rd);
      cpu_req_i  = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_data_i = wd;
      stalls     = 0;
      @(negedge clk);
      while (cpu_stall_o && stalls < 60) begin
         stalls++;
         @(negedge clk);
      end
      chk("stall_cycles", 256'(stalls), 256'(exp_stall));
      if (!we) chk("load_data", 256'(cpu_data_o), 256'(exp_rd));
      @(posedge clk);
      #1;
      cpu_req_i = 1'b0;
      cpu_we_i  = 1'b0;
   endtask

   task automatic check_stats();
`ifdef DCACHE_STATS_EN
      chk("hit_cnt", 256'(hit_cnt_o), 256'(m_hits));
      chk("miss_cnt", 256'(miss_cnt_o), 256'(m_misses));
`endif
   endtask

   initial begin : main
      int          es;
      logic [31:0] er;
      logic [31:0] a;
      bit          we;
      rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
      cpu_addr_i = 32'h0; cpu_data_i = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_enable", 256'(mem_enable_o), 256'(0));
      chk("rst_write", 256'(mem_write_o), 256'(0));
      chk("rst_addr", 256'(mem_addr_o), 256'(0));
      chk("rst_data", mem_data_o, 256'(0));
      chk("rst_stall_idle", 256'(cpu_stall_o), 256'(0));
      check_stats();
      @(posedge clk);
      #1;
      rst_i = 1'b0;

      // clean miss, store hit, dirty eviction, re-fetch of the written-back line
      do_access(1'b0, 32'h0000_0040, 32'h0);
      do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
      do_access(1'b0, 32'h0000_0044, 32'h0);
      do_access(1'b0, 32'h0000_0444, 32'h0);
      do_access(1'b0, 32'h0000_0044, 32'h0);
      check_stats();

      // reset while the refill of 0x80 is outstanding
      model_access(1'b0, 32'h0000_0080, 32'h0, es, er);
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0080;
      repeat (4) @(posedge clk);
      #1;
      rst_i = 1'b1; cpu_req_i = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      model_reset();
      chk("rst_mid_enable", 256'(mem_enable_o), 256'(0));
      chk("rst_mid_addr", 256'(mem_addr_o), 256'(0));
      chk("rst_mid_stall", 256'(cpu_stall_o), 256'(0));
      do_access(1'b0, 32'h0000_0080, 32'h0);
      do_access(1'b0, 32'h0000_0044, 32'h0);
      check_stats();

      // request withdrawn mid-miss: refill still completes into the latched line
      model_access(1'b0, 32'h0000_01C0, 32'h0, es, er);
      m_hits--;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_01C0;
      repeat (3) @(posedge clk);
      #1;
      cpu_req_i = 1'b0; cpu_addr_i = 32'hFFFF_FFE0;
      repeat (30) @(posedge clk);
      #1;
      chk("drop_drained", 256'(exp_q.size()), 256'(0));
      do_access(1'b0, 32'h0000_01C4, 32'h0);
      check_stats();

      // random traffic over 4 sets x 4 tags
      for (int i = 0; i < 300; i++) begin
         a  = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)), 2'b00};
         we = 1'($urandom_range(0, 1));
         do_access(we, a, $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      chk("final_drained", 256'(exp_q.size()), 256'(0));
      check_stats();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
